// File: rtl/line_encoder_32to5_seq_if.sv
// Handshake bundle for the sequential line encoder: vector-in stream and
// index-out stream with valid/ready flow control on both sides.
interface line_encoder_32to5_seq_if #(
  parameter int N_LINES = 32,
  parameter int IDX_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [N_LINES-1:0] in_vec;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               out_none;

  // Producer of vectors / consumer of indices.
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_none
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_none
  );
endinterface

// File: rtl/line_encoder_32to5_seq.sv
// Sequential 32-to-5 line encoder. Captures a multi-hot line vector and
// emits the binary index of each set line, one per output handshake, in
// fixed priority order (lowest or highest first). An all-zero vector yields
// a single "none" output.
module line_encoder_32to5_seq #(
  parameter int N_LINES   = 32,
  parameter int IDX_W     = 5,
  parameter int LSB_FIRST = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  line_encoder_32to5_seq_if.slave       bus
);

  localparam int unsigned N = N_LINES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [N_LINES-1:0] pending, pending_nxt;
  logic [IDX_W-1:0]   pri_idx;
  logic [N_LINES-1:0] pri_hit;
  logic               single;

  // Priority pick over the pending lines; the later loop assignment wins,
  // so the loop direction is the reverse of the emission order.
  always_comb begin
    pri_idx = '0;
    pri_hit = '0;
    if (LSB_FIRST != 0) begin
      for (int unsigned i = N; i > 0; i--) begin
        if (pending[i-1]) pri_idx = IDX_W'(i - 1);
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (pending[i]) pri_idx = IDX_W'(i);
      end
    end
    pri_hit[pri_idx] = 1'b1;
  end

  // Exactly one line left means the current index is the final one.
  always_comb begin
    single = (pending != '0) && ((pending & (pending - 1'b1)) == '0);
  end

  // State and pending-line register; reset discards any partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // Next-state and pending update on accept/emit handshakes.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          pending_nxt = bus.in_vec;
          state_nxt   = (bus.in_vec == '0) ? EMPTY : EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          pending_nxt = pending & ~pri_hit;
          if (single) state_nxt = IDLE;
        end
      end
      EMPTY: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
      end
    endcase
  end

  // Handshake outputs depend only on registered state and pending lines.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == EMIT) || (state == EMPTY);
    bus.out_none  = (state == EMPTY);
    bus.out_last  = (state == EMPTY) || ((state == EMIT) && single);
    bus.out_idx   = (state == EMIT) ? pri_idx : '0;
  end

endmodule

// File: tb/tb_line_encoder_32to5_seq.sv
// Self-checking bench for line_encoder_32to5_seq: one LSB-first and one
// MSB-first instance, randomized vectors and stalls against a queue model.
module tb_line_encoder_32to5_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  line_encoder_32to5_seq_if #(.N_LINES(32), .IDX_W(5)) bus_l ();
  line_encoder_32to5_seq_if #(.N_LINES(32), .IDX_W(5)) bus_m ();

  line_encoder_32to5_seq #(.N_LINES(32), .IDX_W(5), .LSB_FIRST(1)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l.slave)
  );

  line_encoder_32to5_seq #(.N_LINES(32), .IDX_W(5), .LSB_FIRST(0)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of set line numbers in emission order.
  task automatic build_exp(input logic [31:0] v, input bit lsb);
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      if (v[k]) begin
        if (lsb) exp_q.push_back(k);
        else     exp_q.push_front(k);
      end
    end
    if (v == 32'h0) exp_q.push_back(0);
  endtask

  // Run one vector through the LSB-first instance. abort_at >= 0 asserts
  // reset once that many indices have been consumed.
  task automatic run_vec(input logic [31:0] v, input bit stall, input int abort_at);
    int   n;
    int   stalls;
    bit   rdy;
    logic last_exp;
    build_exp(v, 1'b1);
    @(negedge clk);
    chk("idle_in_ready", bus_l.in_ready, 1);
    chk("idle_out_valid", bus_l.out_valid, 0);
    bus_l.in_valid = 1'b1;
    bus_l.in_vec   = v;
    @(negedge clk);
    bus_l.in_valid = 1'b0;
    bus_l.in_vec   = $urandom;
    n = 0;
    stalls = 0;
    while (exp_q.size() > 0) begin
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_out_valid", bus_l.out_valid, 0);
        chk("rst_in_ready", bus_l.in_ready, 1);
        chk("rst_out_idx", 32'(bus_l.out_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      last_exp = (exp_q.size() == 1);
      chk("out_valid", bus_l.out_valid, 1);
      chk("busy_in_ready", bus_l.in_ready, 0);
      chk("out_idx", 32'(bus_l.out_idx), 32'(exp_q[0]));
      chk("out_last", bus_l.out_last, last_exp);
      chk("out_none", bus_l.out_none, (v == 32'h0));
      if ($countones(v) == 1) chk("redecode", 32'h1 << bus_l.out_idx, v);
      if (stall) rdy = ($urandom_range(0, 2) != 0) || (stalls >= 4);
      else       rdy = 1'b1;
      stalls = rdy ? 0 : stalls + 1;
      bus_l.out_ready = rdy;
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        n++;
      end
    end
    chk("done_out_valid", bus_l.out_valid, 0);
    chk("done_in_ready", bus_l.in_ready, 1);
  endtask

  // Run one vector through the MSB-first instance with no stalls.
  task automatic run_msb(input logic [31:0] v);
    build_exp(v, 1'b0);
    @(negedge clk);
    chk("m_idle_in_ready", bus_m.in_ready, 1);
    bus_m.in_valid = 1'b1;
    bus_m.in_vec   = v;
    bus_m.out_ready = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    bus_m.in_vec   = $urandom;
    while (exp_q.size() > 0) begin
      chk("m_out_valid", bus_m.out_valid, 1);
      chk("m_out_idx", 32'(bus_m.out_idx), 32'(exp_q[0]));
      chk("m_out_last", bus_m.out_last, (exp_q.size() == 1));
      chk("m_out_none", bus_m.out_none, (v == 32'h0));
      @(negedge clk);
      void'(exp_q.pop_front());
    end
    chk("m_done_out_valid", bus_m.out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    bus_l.in_valid  = 1'b1;
    bus_l.in_vec    = 32'h0000_0005;
    bus_l.out_ready = 1'b1;
    bus_m.in_valid  = 1'b0;
    bus_m.in_vec    = '0;
    bus_m.out_ready = 1'b1;

    // Reset held with in_valid asserted: nothing may be accepted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_out_valid", bus_l.out_valid, 0);
      chk("rst_hold_in_ready", bus_l.in_ready, 1);
    end
    bus_l.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", bus_l.out_valid, 0);

    // One-hot sweep.
    for (int k = 0; k < 32; k++) run_vec(32'h1 << k, 1'b0, -1);

    // Mixed vector, both priority orders.
    run_vec(32'h8000_0011, 1'b0, -1);
    run_msb(32'h8000_0011);

    // All-zero vector.
    run_vec(32'h0, 1'b0, -1);
    run_msb(32'h0);

    // All lines set with random backpressure.
    run_vec(32'hFFFF_FFFF, 1'b1, -1);

    // Random sparse vectors with random backpressure.
    for (int r = 0; r < 20; r++) begin
      v = $urandom & $urandom;
      run_vec(v, 1'b1, -1);
    end
    for (int r = 0; r < 5; r++) begin
      v = $urandom & $urandom & $urandom;
      run_msb(v);
    end

    // Reset in the middle of a full vector, then a fresh single-line vector.
    run_vec(32'hFFFF_FFFF, 1'b1, 13);
    bus_l.out_ready = 1'b1;
    run_vec(32'h0000_0100, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
